if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter, issues requests to instruction memory over a request/grant/response handshake, buffers returned instructions, and drives the IF/ID pipeline register consumed by decode and the ID/EX register. Stall holds IF/ID, and flush redirects the PC after a taken branch or jump.

---
 rtl/if_pkg.sv | 26 ++
 rtl/if_fetch_stage_fetch_buf.sv | 55 +++++
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 tb/tb_if_fetch_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Build option IF_SKID_BUF_EN selects a two-entry fetch buffer instead of one.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

`ifdef IF_SKID_BUF_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_fetch_buf.sv
// fetch_buf: small in-order FIFO of fetched {pc, instr} entries.
// Entry 0 is always the head; a pop shifts the remaining entries down.
module fetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem   [DEPTH];
  fetch_entry_t mem_n [DEPTH];
  logic [CW-1:0] wr_idx;

  // A simultaneous pop and push writes the new entry into the slot the shift frees.
  always_comb begin
    mem_n  = mem;
    wr_idx = count - CW'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) mem_n[i] = push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      mem   <= '{default: '0};
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      mem   <= mem_n;
    end
  end

  assign head  = mem[0];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, instruction-memory handshake FSM and IF/ID register.
// Buffer depth is 1 by default, 2 when IF_SKID_BUF_EN is defined.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_IF_ID,
  output logic [XLEN-1:0] inCode_IF_ID,
  output logic [XLEN-1:0] returnAddr_IF_ID,
  output logic            valid_IF_ID
);

  localparam int CW = $clog2(FETCH_DEPTH + 1);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            req, push, pop, space, outstanding;
  fetch_entry_t    head;
  logic [CW-1:0]   count;
  logic            full, empty;

  assign pop         = !flush && !stall && !empty;
  assign push        = (state == WAIT) && imem_rvalid && !flush && (!full || pop);
  assign outstanding = (state == WAIT);

  // The in-flight word already owns a slot, so a new request needs one more beyond it.
  assign space = (int'(count) + int'(outstanding) - int'(pop)) < FETCH_DEPTH;

  assign imem_req  = req && !flush && reset;
  assign imem_addr = pc;

  fetch_buf #(.DEPTH(FETCH_DEPTH)) u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: inflight_pc, instr: imem_rdata}),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= REQ;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    req     = 1'b0;
    case (state)
      REQ: begin
        req = 1'b1;
        if (imem_gnt) state_n = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (space) begin
            req     = 1'b1;
            state_n = imem_gnt ? WAIT : REQ;
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (space) state_n = REQ;
      end
      DROP: begin
        if (imem_rvalid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
    // A response still in flight at flush time must be swallowed in DROP.
    if (flush) begin
      state_n = ((state == WAIT || state == DROP) && !imem_rvalid) ? DROP : REQ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC & ~XLEN'(3);
      inflight_pc <= '0;
    end else if (flush) begin
      pc <= redirect_pc & ~XLEN'(3);
    end else if (imem_req && imem_gnt) begin
      pc          <= pc + XLEN'(PC_INCR);
      inflight_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_IF_ID         <= '0;
      inCode_IF_ID     <= '0;
      returnAddr_IF_ID <= '0;
      valid_IF_ID      <= 1'b0;
    end else if (flush) begin
      pc_IF_ID         <= '0;
      inCode_IF_ID     <= '0;
      returnAddr_IF_ID <= '0;
      valid_IF_ID      <= 1'b0;
    end else if (!stall) begin
      if (!empty) begin
        pc_IF_ID         <= head.pc;
        inCode_IF_ID     <= head.instr;
        returnAddr_IF_ID <= head.pc + XLEN'(PC_INCR);
        valid_IF_ID      <= 1'b1;
      end else begin
        pc_IF_ID         <= '0;
        inCode_IF_ID     <= '0;
        returnAddr_IF_ID <= '0;
        valid_IF_ID      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized and directed stimulus against a queue-based
// fetch model with an epoch-tagged memory responder.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_IF_ID, inCode_IF_ID, returnAddr_IF_ID;
  logic        valid_IF_ID;

  int checks = 0;
  int errors = 0;

  // Memory responder and reference model state
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_tag = 0;
  int unsigned mem_delay = 0;
  int unsigned max_delay = 0;
  int unsigned gnt_pct = 100;
  int          hold_gnt = 0;
  int          epoch = 0;
  int          delivered = 0;
  logic [31:0] exp_buf[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] fetch_ptr = RST_PC;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .pc_IF_ID         (pc_IF_ID),
    .inCode_IF_ID     (inCode_IF_ID),
    .returnAddr_IF_ID (returnAddr_IF_ID),
    .valid_IF_ID      (valid_IF_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("valid_IF_ID", {31'b0, valid_IF_ID}, {31'b0, exp_valid});
    chk("pc_IF_ID", pc_IF_ID, exp_pc);
    chk("inCode_IF_ID", inCode_IF_ID, exp_valid ? mem_word(exp_pc) : 32'h0);
    chk("returnAddr_IF_ID", returnAddr_IF_ID, exp_valid ? exp_pc + 32'd4 : 32'h0);
  endtask

  // One clock cycle: drive inputs, answer the request, advance the model, check.
  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] r);
    logic        req_s, g;
    logic [31:0] addr_s;
    @(negedge clk);
    stall       = s;
    flush       = f;
    redirect_pc = r;
    imem_rvalid = mem_pend && (mem_delay == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    #1;
    req_s    = imem_req;
    addr_s   = imem_addr;
    g        = req_s && (hold_gnt == 0) && ($urandom_range(99) < gnt_pct);
    imem_gnt = g;
    if (req_s) chk("addr_align", addr_s & 32'h3, 32'h0);
    if (prev_hold && req_s) chk("addr_stable", addr_s, prev_addr);
    if (g) begin
      chk("fetch_addr", addr_s, fetch_ptr);
      fetch_ptr = fetch_ptr + 32'd4;
    end
    prev_hold = req_s && !g;
    prev_addr = addr_s;
    @(posedge clk);
    if (f) begin
      exp_buf.delete();
      exp_valid = 1'b0;
      exp_pc    = '0;
    end else if (!s) begin
      if (exp_buf.size() > 0) begin
        exp_valid = 1'b1;
        exp_pc    = exp_buf.pop_front();
        delivered++;
      end else begin
        exp_valid = 1'b0;
        exp_pc    = '0;
      end
    end
    if (imem_rvalid && !f && mem_tag == epoch) exp_buf.push_back(mem_addr);
    if (f) begin
      epoch++;
      fetch_ptr = r & ~32'h3;
    end
    if (imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend && mem_delay > 0) mem_delay--;
    if (g) begin
      mem_pend  = 1'b1;
      mem_addr  = addr_s;
      mem_tag   = epoch;
      mem_delay = $urandom_range(max_delay);
    end
    if (hold_gnt > 0) hold_gnt--;
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, valid_IF_ID}, 32'h0);
    chk("rst_pc", pc_IF_ID, 32'h0);
    chk("rst_inCode", inCode_IF_ID, 32'h0);
    chk("rst_returnAddr", returnAddr_IF_ID, 32'h0);
    repeat (cycles) @(negedge clk);
    chk("rst_req_held", {31'b0, imem_req}, 32'h0);
    reset = 1'b1;
    epoch++;
    exp_buf.delete();
    exp_valid = 1'b0;
    exp_pc    = '0;
    fetch_ptr = RST_PC;
    prev_hold = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RST_PC);
  endtask

  initial begin
    $display("[TB] if_fetch_stage bench start");
    doReset(3);

    // Straight-line streaming with immediate grant and response
    gnt_pct = 100; max_delay = 0;
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

    // Short stall, then a long one that must fill the buffer and drop the request
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
    chk("req_drop_full", {31'b0, imem_req}, 32'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);

    // Flush to 0x100 while the 0x10 request is outstanding
    doReset(1);
    for (int i = 0; i < 40 && fetch_ptr != 32'h14; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    chk("reach_0x10", fetch_ptr, 32'h14);
    mem_delay = 2;
    applyStimulus(1'b0, 1'b1, 32'h100);
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);

    // Flush coinciding with a response, misaligned redirect
    applyStimulus(1'b0, 1'b1, 32'h203);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0);

    // Flush together with stall
    applyStimulus(1'b1, 1'b1, 32'h300);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0);

    // Grant withheld at 0x20
    applyStimulus(1'b0, 1'b1, 32'h20);
    hold_gnt = 6;
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);
    chk("gnt_hold_req", {31'b0, imem_req}, 32'h1);
    chk("gnt_hold_addr", imem_addr, 32'h20);
    chk("gnt_hold_ptr", fetch_ptr, 32'h20);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);

    // PC wrap from the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    chk("wrap_fetch", {28'b0, fetch_ptr[31:28]}, 32'h0);

    // Reset while a response is still pending; the stray word must be ignored
    max_delay = 3;
    for (int i = 0; i < 20 && !(mem_pend && mem_delay > 0); i++) applyStimulus(1'b0, 1'b0, 32'h0);
    chk("pending_before_reset", {31'b0, mem_pend}, 32'h1);
    doReset(2);
    mem_delay = 0;
    max_delay = 0;
    hold_gnt  = 2;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);

    // Randomized traffic
    gnt_pct   = 70;
    max_delay = 2;
    for (int i = 0; i < 400; i++) begin
      logic        s, f;
      logic [31:0] r;
      s = ($urandom_range(99) < 25);
      f = ($urandom_range(99) < 4);
      r = $urandom;
      applyStimulus(s, f, r);
    end
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    chk("progress", {31'b0, delivered > 40}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
